cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_pkg.sv | 20 ++
 rtl/cdb_fifo.sv | 61 ++++++
 rtl/cdb_arbiter.sv | 123 ++++++++++++
 tb/tb_cdb_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_pkg.sv
// Shared types and constants for the common-data-bus arbiter.
//   REG_W / TAG_W / DATA_W : destination register, tag and result widths
//   cdb_entry_t            : one buffered result (dst, tag, data)
//   SRC_INT / SRC_MEM      : encoding of the broadcast source
package cdb_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned TAG_W  = 5;
    localparam int unsigned DATA_W = 32;

    typedef struct packed {
        logic [REG_W-1:0]  dst;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } cdb_entry_t;

    localparam logic SRC_INT = 1'b0;
    localparam logic SRC_MEM = 1'b1;

endpackage

// File: rtl/cdb_fifo.sv
// Per-source result FIFO feeding the CDB arbiter.
//   clk, rst (sync, active-high), flush : clock, reset, discard contents
//   push, din                           : write request and entry (ignored when full)
//   pop                                 : read request (ignored when empty)
//   full, empty, head                   : status from registered count, oldest entry
module cdb_fifo
    import cdb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       push,
    input  cdb_entry_t din,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output cdb_entry_t head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    cdb_entry_t       r_mem [DEPTH];

    logic w_push;
    logic w_pop;

    assign full   = (r_count == CNT_W'(DEPTH));
    assign empty  = (r_count == '0);
    assign head   = r_mem[r_rd_ptr];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; validity is tracked by the count.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Merges integer-pipe and load-pipe results onto a registered common data bus.
// Config macro: CDB_RR_ARB_EN -- round-robin between sources when both are
// pending; undefined selects fixed priority with INT always winning.
//   clk, rst (sync, active-high)            : clock and reset
//   int_we/dst/tag/data, int_ready          : integer-pipe result in, FIFO not full
//   mem_we/dst/tag/data, mem_ready          : load-pipe result in, FIFO not full
//   flush                                   : drop all buffered and in-flight results
//   cdb_stall                               : consumer back-pressure, holds cdb_*
//   cdb_valid/dst/tag/data, cdb_src         : registered broadcast and its source
//   cdb_rf_we                               : register-file write enable (dst != 0)
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              int_we,
    input  logic [REG_W-1:0]  int_dst,
    input  logic [TAG_W-1:0]  int_tag,
    input  logic [DATA_W-1:0] int_data,
    output logic              int_ready,
    input  logic              mem_we,
    input  logic [REG_W-1:0]  mem_dst,
    input  logic [TAG_W-1:0]  mem_tag,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    input  logic              flush,
    input  logic              cdb_stall,
    output logic              cdb_valid,
    output logic [REG_W-1:0]  cdb_dst,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_data,
    output logic              cdb_rf_we,
    output logic              cdb_src
);

    cdb_entry_t w_int_in, w_mem_in, w_int_head, w_mem_head, w_sel;
    logic       w_int_full, w_mem_full, w_int_empty, w_mem_empty;
    logic       w_int_ne, w_mem_ne, w_do_pop, w_grant_src;

    logic       r_cdb_valid;
    logic       r_cdb_src;
    cdb_entry_t r_cdb;

    assign w_int_in = '{dst: int_dst, tag: int_tag, data: int_data};
    assign w_mem_in = '{dst: mem_dst, tag: mem_tag, data: mem_data};
    assign w_int_ne = !w_int_empty;
    assign w_mem_ne = !w_mem_empty;
    assign w_do_pop = !flush && !cdb_stall && (w_int_ne || w_mem_ne);

    cdb_fifo #(.DEPTH(DEPTH)) u_int_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (int_we),
        .din   (w_int_in),
        .pop   (w_do_pop && (w_grant_src == SRC_INT)),
        .full  (w_int_full),
        .empty (w_int_empty),
        .head  (w_int_head)
    );

    cdb_fifo #(.DEPTH(DEPTH)) u_mem_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (mem_we),
        .din   (w_mem_in),
        .pop   (w_do_pop && (w_grant_src == SRC_MEM)),
        .full  (w_mem_full),
        .empty (w_mem_empty),
        .head  (w_mem_head)
    );

`ifdef CDB_RR_ARB_EN
    logic r_last_grant;

    // When both sources are pending, the one not served last wins.
    always_comb begin
        w_grant_src = SRC_INT;
        if (w_int_ne && w_mem_ne) w_grant_src = ~r_last_grant;
        else if (w_mem_ne)        w_grant_src = SRC_MEM;
    end

    always_ff @(posedge clk) begin
        if (rst)           r_last_grant <= SRC_INT;
        else if (w_do_pop) r_last_grant <= w_grant_src;
    end
`else
    // Fixed priority: MEM only when INT has nothing pending.
    assign w_grant_src = (!w_int_ne && w_mem_ne) ? SRC_MEM : SRC_INT;
`endif

    assign w_sel = (w_grant_src == SRC_MEM) ? w_mem_head : w_int_head;

    // Broadcast register: flush beats stall; stall freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cdb_valid <= 1'b0;
            r_cdb_src   <= SRC_INT;
            r_cdb       <= '0;
        end else if (flush) begin
            r_cdb_valid <= 1'b0;
        end else if (!cdb_stall) begin
            r_cdb_valid <= w_do_pop;
            if (w_do_pop) begin
                r_cdb     <= w_sel;
                r_cdb_src <= w_grant_src;
            end
        end
    end

    assign int_ready = !w_int_full;
    assign mem_ready = !w_mem_full;
    assign cdb_valid = r_cdb_valid;
    assign cdb_dst   = r_cdb.dst;
    assign cdb_tag   = r_cdb.tag;
    assign cdb_data  = r_cdb.data;
    assign cdb_src   = r_cdb_src;
    assign cdb_rf_we = r_cdb_valid && (r_cdb.dst != '0);

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        int_we, mem_we, flush, cdb_stall;
    logic [4:0]  int_dst, int_tag, mem_dst, mem_tag;
    logic [31:0] int_data, mem_data;
    logic        int_ready, mem_ready, cdb_valid, cdb_rf_we, cdb_src;
    logic [4:0]  cdb_dst, cdb_tag;
    logic [31:0] cdb_data;

    int total = 0;
    int bad   = 0;

    cdb_arbiter #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .int_we    (int_we),
        .int_dst   (int_dst),
        .int_tag   (int_tag),
        .int_data  (int_data),
        .int_ready (int_ready),
        .mem_we    (mem_we),
        .mem_dst   (mem_dst),
        .mem_tag   (mem_tag),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .flush     (flush),
        .cdb_stall (cdb_stall),
        .cdb_valid (cdb_valid),
        .cdb_dst   (cdb_dst),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .cdb_rf_we (cdb_rf_we),
        .cdb_src   (cdb_src)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       iw;
        logic [4:0] idst, itag;
        logic       mw;
        logic [4:0] mdst, mtag;
        logic       fl, st;
        logic       ev, esrc;
        logic [4:0] edst, etag;
        logic       eir, emr;
    } vec_t;

    function automatic vec_t mk(int iw, int idst, int itag, int mw, int mdst, int mtag,
                                int fl, int st, int ev, int esrc, int edst, int etag,
                                int eir, int emr);
        vec_t v;
        v.iw = 1'(iw);   v.idst = 5'(idst); v.itag = 5'(itag);
        v.mw = 1'(mw);   v.mdst = 5'(mdst); v.mtag = 5'(mtag);
        v.fl = 1'(fl);   v.st = 1'(st);
        v.ev = 1'(ev);   v.esrc = 1'(esrc); v.edst = 5'(edst); v.etag = 5'(etag);
        v.eir = 1'(eir); v.emr = 1'(emr);
        return v;
    endfunction

    // Result data is derived from the tag so every entry is distinguishable.
    function automatic logic [31:0] int_dat(logic [4:0] t);
        return 32'hDEADBEE8 + 32'(t);
    endfunction
    function automatic logic [31:0] mem_dat(logic [4:0] t);
        return 32'h12340000 + 32'(t);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(logic iw, logic [4:0] idst, logic [4:0] itag,
                         logic mw, logic [4:0] mdst, logic [4:0] mtag,
                         logic fl, logic st);
        int_we = iw; int_dst = idst; int_tag = itag; int_data = int_dat(itag);
        mem_we = mw; mem_dst = mdst; mem_tag = mtag; mem_data = mem_dat(mtag);
        flush = fl; cdb_stall = st;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bcast(string n, logic esrc, logic [4:0] edst, logic [4:0] etag);
        chk({n, "_valid"}, 32'(cdb_valid), 32'd1);
        chk({n, "_src"},   32'(cdb_src),   32'(esrc));
        chk({n, "_dst"},   32'(cdb_dst),   32'(edst));
        chk({n, "_tag"},   32'(cdb_tag),   32'(etag));
        chk({n, "_data"},  cdb_data, esrc ? mem_dat(etag) : int_dat(etag));
        chk({n, "_rfwe"},  32'(cdb_rf_we), 32'(edst != 5'd0));
    endtask

    localparam int NV = 35;
    vec_t tbl [NV];
    int   exp_src [8];
    int   exp_tag [8];

    initial begin
        // Stimulus rows: inputs before an edge, expected outputs after it.
        tbl[0]  = mk(1,3,7,  0,0,0,  0,0, 0,0,0,0,  1,1);
        tbl[1]  = mk(0,0,0,  0,0,0,  0,0, 1,0,3,7,  1,1);
        tbl[2]  = mk(0,0,0,  0,0,0,  0,0, 0,0,0,0,  1,1);
        tbl[3]  = mk(0,0,0,  1,0,9,  0,0, 0,0,0,0,  1,1);
        tbl[4]  = mk(0,0,0,  0,0,0,  0,0, 1,1,0,9,  1,1);
        tbl[5]  = mk(0,0,0,  0,0,0,  0,0, 0,0,0,0,  1,1);
        tbl[6]  = mk(1,4,1,  1,5,2,  0,0, 0,0,0,0,  1,1);
        tbl[7]  = mk(0,0,0,  0,0,0,  0,0, 1,0,4,1,  1,1);
        tbl[8]  = mk(0,0,0,  0,0,0,  0,0, 1,1,5,2,  1,1);
        tbl[9]  = mk(0,0,0,  0,0,0,  0,0, 0,0,0,0,  1,1);
        tbl[10] = mk(1,6,10, 0,0,0,  0,1, 0,0,0,0,  1,1);
        tbl[11] = mk(1,6,11, 0,0,0,  0,1, 0,0,0,0,  1,1);
        tbl[12] = mk(1,6,12, 0,0,0,  0,1, 0,0,0,0,  1,1);
        tbl[13] = mk(1,6,13, 0,0,0,  0,1, 0,0,0,0,  0,1);
        tbl[14] = mk(1,6,14, 0,0,0,  0,1, 0,0,0,0,  0,1);
        tbl[15] = mk(1,6,14, 0,0,0,  0,0, 1,0,6,10, 1,1);
        tbl[16] = mk(1,6,14, 0,0,0,  0,0, 1,0,6,11, 1,1);
        tbl[17] = mk(0,0,0,  0,0,0,  0,0, 1,0,6,12, 1,1);
        tbl[18] = mk(0,0,0,  0,0,0,  0,0, 1,0,6,13, 1,1);
        tbl[19] = mk(0,0,0,  0,0,0,  0,0, 1,0,6,14, 1,1);
        tbl[20] = mk(0,0,0,  0,0,0,  0,0, 0,0,0,0,  1,1);
        tbl[21] = mk(1,2,20, 0,0,0,  0,0, 0,0,0,0,  1,1);
        tbl[22] = mk(1,2,21, 0,0,0,  0,0, 1,0,2,20, 1,1);
        tbl[23] = mk(0,0,0,  0,0,0,  0,1, 1,0,2,20, 1,1);
        tbl[24] = mk(0,0,0,  0,0,0,  0,1, 1,0,2,20, 1,1);
        tbl[25] = mk(0,0,0,  0,0,0,  0,0, 1,0,2,21, 1,1);
        tbl[26] = mk(0,0,0,  0,0,0,  0,0, 0,0,0,0,  1,1);
        tbl[27] = mk(1,2,24, 0,0,0,  0,0, 0,0,0,0,  1,1);
        tbl[28] = mk(1,2,25, 1,7,26, 0,0, 1,0,2,24, 1,1);
        tbl[29] = mk(1,2,27, 0,0,0,  0,1, 1,0,2,24, 1,1);
        tbl[30] = mk(1,2,28, 0,0,0,  1,1, 0,0,0,0,  1,1);
        tbl[31] = mk(0,0,0,  0,0,0,  0,0, 0,0,0,0,  1,1);
        tbl[32] = mk(0,0,0,  0,0,0,  0,0, 0,0,0,0,  1,1);
        tbl[33] = mk(1,3,29, 0,0,0,  0,0, 0,0,0,0,  1,1);
        tbl[34] = mk(0,0,0,  0,0,0,  0,0, 1,0,3,29, 1,1);

`ifdef CDB_RR_ARB_EN
        exp_src = '{1, 0, 1, 0, 1, 0, 1, 0};
        exp_tag = '{24, 16, 25, 17, 26, 18, 27, 19};
`else
        exp_src = '{0, 0, 0, 0, 1, 1, 1, 1};
        exp_tag = '{16, 17, 18, 19, 24, 25, 26, 27};
`endif

        // Reset state
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("rst_int_ready", 32'(int_ready), 32'd1);
        chk("rst_mem_ready", 32'(mem_ready), 32'd1);
        chk("rst_rf_we",     32'(cdb_rf_we), 32'd0);
        tick();
        chk("rst_valid",     32'(cdb_valid), 32'd0);
        chk("rst_fields",    {cdb_data[20:0], cdb_dst, cdb_tag, cdb_src}, 32'd0);
        rst = 1'b0;

        // Directed vector table
        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].iw, tbl[i].idst, tbl[i].itag, tbl[i].mw, tbl[i].mdst, tbl[i].mtag,
                  tbl[i].fl, tbl[i].st);
            tick();
            chk($sformatf("v%0d_int_ready", i), 32'(int_ready), 32'(tbl[i].eir));
            chk($sformatf("v%0d_mem_ready", i), 32'(mem_ready), 32'(tbl[i].emr));
            if (tbl[i].ev)
                chk_bcast($sformatf("v%0d", i), tbl[i].esrc, tbl[i].edst, tbl[i].etag);
            else begin
                chk($sformatf("v%0d_valid", i), 32'(cdb_valid), 32'd0);
                chk($sformatf("v%0d_rfwe", i),  32'(cdb_rf_we), 32'd0);
            end
        end

        // Both sources pushing for four cycles: arbitration order
        for (int c = 0; c < 4; c++) begin
            drive(1, 5'd1, 5'(16 + c), 1, 5'd2, 5'(24 + c), 0, 0);
            tick();
            if (c == 0) chk("arb_first_valid", 32'(cdb_valid), 32'd0);
            else chk_bcast($sformatf("arb%0d", c - 1), 1'(exp_src[c-1]),
                           exp_src[c-1] != 0 ? 5'd2 : 5'd1, 5'(exp_tag[c-1]));
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 3; c < 8; c++) begin
            tick();
            chk_bcast($sformatf("arb%0d", c), 1'(exp_src[c]),
                      exp_src[c] != 0 ? 5'd2 : 5'd1, 5'(exp_tag[c]));
        end
        tick();
        chk("arb_drained_valid", 32'(cdb_valid), 32'd0);

        // Reset mid-stream discards buffered entries
        drive(1, 5'd4, 5'd3, 1, 5'd4, 5'd4, 0, 0);
        tick();
        drive(1, 5'd4, 5'd5, 0, 0, 0, 0, 0);
        tick();
        chk("mid_pre_valid", 32'(cdb_valid), 32'd1);
        rst = 1'b1;
        drive(1, 5'd4, 5'd6, 1, 5'd4, 5'd7, 0, 0);
        tick();
        rst = 1'b0;
        chk("mid_rst_valid",  32'(cdb_valid), 32'd0);
        chk("mid_rst_fields", {cdb_data[20:0], cdb_dst, cdb_tag, cdb_src}, 32'd0);
        chk("mid_rst_data",   cdb_data, 32'd0);
        chk("mid_rst_rfwe",   32'(cdb_rf_we), 32'd0);
        chk("mid_rst_ready",  {30'd0, int_ready, mem_ready}, 32'd3);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("mid_idle_valid", 32'(cdb_valid), 32'd0);
        drive(1, 5'd8, 5'd8, 0, 0, 0, 0, 0);
        tick();
        chk("mid_push_valid", 32'(cdb_valid), 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk_bcast("mid_push", 1'b0, 5'd8, 5'd8);
        tick();
        chk("mid_end_valid", 32'(cdb_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
